// File: rtl/mdr_wait_if.sv
// Control/handshake bundle between the memory controller and the MDR.
interface mdr_wait_if;
    logic Em;       // drive mdrreg onto WBUS
    logic nLm;      // active-low WBUS load, honoured in IDLE
    logic rd_req;   // start memory read
    logic wr_req;   // start memory write
    logic mem_rd;   // memory read strobe
    logic mem_wr;   // memory write strobe
    logic busy;     // access in progress
    logic done;     // one-cycle completion pulse

    modport master (output Em, nLm, rd_req, wr_req,
                    input  mem_rd, mem_wr, busy, done);
    modport slave  (input  Em, nLm, rd_req, wr_req,
                    output mem_rd, mem_wr, busy, done);
endinterface

// File: rtl/mdr_wait.sv
// Memory data register with request/done handshake and programmable
// memory wait states. Holds one word between WBUS and the RAM data port.
module mdr_wait #(
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             CLK,
    input  logic             nCLR,
    inout  wire [WIDTH-1:0]  WBUS,
    inout  wire [WIDTH-1:0]  data,
    mdr_wait_if.slave        bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state logic; strobes are computed one cycle ahead so they come
    // straight from flops and cover exactly the READ/WRITE states.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdr_d    = mdr_q;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Load may coincide with a request; a write then uses the new word.
                if (!bus.nLm)
                    mdr_d = WBUS;
                if (bus.rd_req) begin
                    state_d  = S_READ;
                    cnt_d    = CNT_LOAD;
                    mem_rd_d = 1'b1;
                end else if (bus.wr_req) begin
                    state_d  = S_WRITE;
                    cnt_d    = CNT_LOAD;
                    mem_wr_d = 1'b1;
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    mdr_d   = data;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    mem_rd_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    mem_wr_d = 1'b1;
                end
            end
            default: begin
                // DONE: requests seen here are ignored until back in IDLE.
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any access at once.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mdr_q    <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mdr_q    <= mdr_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.mem_rd = mem_rd_q;
    assign bus.mem_wr = mem_wr_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    // mem_wr_q is high exactly while in WRITE, so it doubles as data enable.
    assign data = mem_wr_q ? mdr_q : {WIDTH{1'bz}};
    assign WBUS = bus.Em   ? mdr_q : {WIDTH{1'bz}};

endmodule
